// File: rtl/peripheral_gpio_debounce.sv
// Per-pin pad input conditioner: multi-flop synchroniser, per-bit stability-counter
// glitch filter with optional bypass, and registered one-cycle rise/fall pulses.
module peripheral_gpio_debounce #(
  parameter int PDATA_SIZE  = 8,
  parameter int CNT_SIZE    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [PDATA_SIZE-1:0] pad_i,
  input  logic [PDATA_SIZE-1:0] filt_en,
  input  logic [CNT_SIZE-1:0]   threshold,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] rise_o,
  output logic [PDATA_SIZE-1:0] fall_o
);

  logic [PDATA_SIZE-1:0] sync_q [SYNC_STAGES];
  logic [PDATA_SIZE-1:0] sync_d [SYNC_STAGES];
  logic [CNT_SIZE-1:0]   cnt_q  [PDATA_SIZE];
  logic [CNT_SIZE-1:0]   cnt_d  [PDATA_SIZE];
  logic [PDATA_SIZE-1:0] gpio_q, gpio_d;
  logic [PDATA_SIZE-1:0] rise_q, rise_d;
  logic [PDATA_SIZE-1:0] fall_q, fall_d;
  logic [PDATA_SIZE-1:0] sync_s;
  logic [CNT_SIZE-1:0]   thr_m1;
  logic                  thr_zero;

  // Saturating increment; the commit compare normally stops the count first,
  // this only guards against wrapping if threshold moves around mid-count.
  function automatic logic [CNT_SIZE-1:0] cnt_inc(input logic [CNT_SIZE-1:0] c);
    logic [CNT_SIZE-1:0] r;
    if (&c) r = c;
    else    r = c + CNT_SIZE'(1);
    return r;
  endfunction

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign thr_zero = (threshold == '0);
  assign thr_m1   = threshold - CNT_SIZE'(1);

  always_comb begin
    sync_d[0] = pad_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Filter decision per bit: bypass, stable, commit, or keep counting.
  always_comb begin
    gpio_d = gpio_q;
    for (int n = 0; n < PDATA_SIZE; n++) begin
      cnt_d[n] = '0;
      if (!filt_en[n] || thr_zero) begin
        gpio_d[n] = sync_s[n];
      end else if (sync_s[n] != gpio_q[n]) begin
        if (cnt_q[n] >= thr_m1) begin
          gpio_d[n] = sync_s[n];
        end else begin
          cnt_d[n] = cnt_inc(cnt_q[n]);
        end
      end
    end
    rise_d = gpio_d & ~gpio_q;
    fall_d = ~gpio_d & gpio_q;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int n = 0; n < PDATA_SIZE; n++) begin
        cnt_q[n] <= '0;
      end
      gpio_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int n = 0; n < PDATA_SIZE; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
      gpio_q <= gpio_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign gpio_o = gpio_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// Directed testbench for peripheral_gpio_debounce (8 bits, 8-bit counter, 2 sync stages).
module tb_peripheral_gpio_debounce;

  logic       PCLK;
  logic       PRESET;
  logic [7:0] pad_i;
  logic [7:0] filt_en;
  logic [7:0] threshold;
  logic [7:0] gpio_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;

  int checks = 0;
  int errors = 0;

  peripheral_gpio_debounce #(
    .PDATA_SIZE (8),
    .CNT_SIZE   (8),
    .SYNC_STAGES(2)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .pad_i    (pad_i),
    .filt_en  (filt_en),
    .threshold(threshold),
    .gpio_o   (gpio_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance n rising edges, leaving time 1ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    pad_i  = 8'h00;
    tick(2);
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; pad_i = 8'hFF; filt_en = 8'hFF; threshold = 8'd4;
    #2;
    checks++;
    if ({gpio_o, rise_o, fall_o} !== 24'h0) begin
      errors++;
      $display("FAIL reset_async: got gpio=%h rise=%h fall=%h want 00 00 00", gpio_o, rise_o, fall_o);
    end
    tick(3);
    PRESET = 1'b0;
    tick(5);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL reset_rel_e5_gpio: got %h want 00", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'hFF) begin
      errors++; $display("FAIL reset_rel_e6_gpio: got %h want ff", gpio_o);
    end
    checks++;
    if (rise_o !== 8'hFF || fall_o !== 8'h00) begin
      errors++; $display("FAIL reset_rel_e6_pulse: got rise=%h fall=%h want ff 00", rise_o, fall_o);
    end
    tick(1);
    checks++;
    if (rise_o !== 8'h00 || gpio_o !== 8'hFF) begin
      errors++; $display("FAIL reset_rel_e7: got rise=%h gpio=%h want 00 ff", rise_o, gpio_o);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    filt_en = 8'hFF; threshold = 8'd4;
    pad_i = 8'h01;
    tick(3);
    pad_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (gpio_o !== 8'h00 || rise_o !== 8'h00) begin
        errors++; $display("FAIL glitch3_cyc%0d: got gpio=%h rise=%h want 00 00", i, gpio_o, rise_o);
      end
    end
    pad_i = 8'h01;
    tick(4);
    pad_i = 8'h00;
    tick(1);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL pulse4_e5: got gpio=%h want 00", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'h01 || rise_o !== 8'h01) begin
      errors++; $display("FAIL pulse4_e6: got gpio=%h rise=%h want 01 01", gpio_o, rise_o);
    end
    tick(1);
    checks++;
    if (rise_o !== 8'h00 || fall_o !== 8'h00) begin
      errors++; $display("FAIL pulse4_e7: got rise=%h fall=%h want 00 00", rise_o, fall_o);
    end
    tick(2);
    checks++;
    if (gpio_o !== 8'h01 || fall_o !== 8'h00) begin
      errors++; $display("FAIL fall_e9: got gpio=%h fall=%h want 01 00", gpio_o, fall_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'h00 || fall_o !== 8'h01 || rise_o !== 8'h00) begin
      errors++; $display("FAIL fall_e10: got gpio=%h fall=%h rise=%h want 00 01 00", gpio_o, fall_o, rise_o);
    end
    tick(1);
    checks++;
    if (fall_o !== 8'h00) begin
      errors++; $display("FAIL fall_e11: got fall=%h want 00", fall_o);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    logic [7:0] exp_g, exp_r;
    apply_reset();
    filt_en = 8'hFF; threshold = 8'd3;
    seq = 5'b10101;
    for (int i = 1; i <= 10; i++) begin
      pad_i = (i <= 5) ? {4'b0, seq[i-1], 3'b0} : 8'h08;
      tick(1);
      exp_g = (i >= 9) ? 8'h08 : 8'h00;
      exp_r = (i == 9) ? 8'h08 : 8'h00;
      checks++;
      if (gpio_o !== exp_g || rise_o !== exp_r) begin
        errors++;
        $display("FAIL bounce_e%0d: got gpio=%h rise=%h want %h %h", i, gpio_o, rise_o, exp_g, exp_r);
      end
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    filt_en = 8'h0F; threshold = 8'd10;
    pad_i = 8'hFF;
    tick(2);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL bypass_e2: got gpio=%h want 00", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'hF0 || rise_o !== 8'hF0) begin
      errors++; $display("FAIL bypass_e3: got gpio=%h rise=%h want f0 f0", gpio_o, rise_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'hF0 || rise_o !== 8'h00) begin
      errors++; $display("FAIL bypass_e4: got gpio=%h rise=%h want f0 00", gpio_o, rise_o);
    end
    tick(7);
    checks++;
    if (gpio_o !== 8'hF0) begin
      errors++; $display("FAIL bypass_e11: got gpio=%h want f0", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'hFF || rise_o !== 8'h0F) begin
      errors++; $display("FAIL bypass_e12: got gpio=%h rise=%h want ff 0f", gpio_o, rise_o);
    end
    tick(1);
    checks++;
    if (rise_o !== 8'h00) begin
      errors++; $display("FAIL bypass_e13: got rise=%h want 00", rise_o);
    end
    threshold = 8'd0; filt_en = 8'hFF;
    pad_i = 8'h00;
    tick(2);
    checks++;
    if (gpio_o !== 8'hFF) begin
      errors++; $display("FAIL thr0_e2: got gpio=%h want ff", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'h00 || fall_o !== 8'hFF || rise_o !== 8'h00) begin
      errors++; $display("FAIL thr0_e3: got gpio=%h fall=%h rise=%h want 00 ff 00", gpio_o, fall_o, rise_o);
    end
  endtask

  task automatic test_threshold_change();
    apply_reset();
    filt_en = 8'hFF; threshold = 8'd20;
    pad_i = 8'h20;
    tick(12);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL thrchg_e12: got gpio=%h want 00", gpio_o);
    end
    threshold = 8'd5;
    tick(1);
    checks++;
    if (gpio_o !== 8'h20 || rise_o !== 8'h20) begin
      errors++; $display("FAIL thrchg_e13: got gpio=%h rise=%h want 20 20", gpio_o, rise_o);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    filt_en = 8'hFF; threshold = 8'd8;
    pad_i = 8'h04;
    tick(9);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL rstmid_e9: got gpio=%h want 00", gpio_o);
    end
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if ({gpio_o, rise_o, fall_o} !== 24'h0) begin
      errors++; $display("FAIL rstmid_async: got gpio=%h rise=%h fall=%h want 00 00 00", gpio_o, rise_o, fall_o);
    end
    #1 PRESET = 1'b0;
    tick(1);
    checks++;
    if (gpio_o !== 8'h00 || rise_o !== 8'h00) begin
      errors++; $display("FAIL rstmid_r1: got gpio=%h rise=%h want 00 00", gpio_o, rise_o);
    end
    tick(8);
    checks++;
    if (gpio_o !== 8'h00) begin
      errors++; $display("FAIL rstmid_r9: got gpio=%h want 00", gpio_o);
    end
    tick(1);
    checks++;
    if (gpio_o !== 8'h04 || rise_o !== 8'h04) begin
      errors++; $display("FAIL rstmid_r10: got gpio=%h rise=%h want 04 04", gpio_o, rise_o);
    end
  endtask

  initial begin
    PRESET = 1'b1; pad_i = 8'h00; filt_en = 8'hFF; threshold = 8'd4;
    test_reset();
    test_glitch();
    test_bounce();
    test_bypass();
    test_threshold_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
